rf_writeback: RTL and testbench

- Write-side initiator for the core register file.
- Collects results from the single-cycle ALU path and the multi-cycle load path into a small in-order queue, then drains one entry per cycle onto the register file write port (we / wr_address / wr_data).
- Provides combinational forwarding of pending (queued, not yet written) values to the two decode read addresses, so decode never reads a stale register.
- Sits between execute/load and the register file.

---
 rtl/rf_writeback.sv | 134 +++++++++++++
 tb/tb_rf_writeback.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// rf_writeback: in-order write-back queue feeding the register file write
// port, with youngest-entry forwarding to the two decode read ports.
// Revision: 1.0
// ============================================================================
module rf_writeback #(
  parameter int DW    = 8,
  parameter int RFW   = 2,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [RFW-1:0]               alu_addr,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_stall,
  input  logic                         ld_valid,
  input  logic [RFW-1:0]               ld_addr,
  input  logic [DW-1:0]                ld_data,
  output logic                         ld_ready,
  input  logic                         rf_hold,
  output logic                         rf_we,
  output logic [RFW-1:0]               rf_wr_address,
  output logic [DW-1:0]                rf_wr_data,
  input  logic [RFW-1:0]               rr1_address,
  input  logic [RFW-1:0]               rr2_address,
  output logic                         fwd1_hit,
  output logic [DW-1:0]                fwd1_data,
  output logic                         fwd2_hit,
  output logic [DW-1:0]                fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RFW-1:0] mem_addr_q [DEPTH];
  logic [RFW-1:0] mem_addr_d [DEPTH];
  logic [DW-1:0]  mem_data_q [DEPTH];
  logic [DW-1:0]  mem_data_d [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic           drain;
  logic [CW-1:0]  free;
  logic           alu_need, alu_acc, ld_acc;
  logic [PW-1:0]  ld_slot;
  logic [PW:0]    scan_sum;
  logic [PW-1:0]  scan_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    drain     = (count_q != '0) && !rf_hold;
    free      = CW'(DEPTH) - count_q + CW'(drain);
    alu_need  = alu_valid && (alu_addr != '0);
    alu_stall = alu_need && (free == '0);
    alu_acc   = alu_need && !alu_stall;
    // The ALU claims its slot first; the load only sees what remains.
    ld_ready  = (ld_addr == '0) || (free > CW'(alu_acc));
    ld_acc    = ld_valid && (ld_addr != '0) && ld_ready;
    ld_slot   = alu_acc ? ptr_inc(tail_q) : tail_q;

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (alu_acc) begin
      mem_addr_d[tail_q] = alu_addr;
      mem_data_d[tail_q] = alu_data;
    end
    if (ld_acc) begin
      mem_addr_d[ld_slot] = ld_addr;
      mem_data_d[ld_slot] = ld_data;
    end

    tail_d = ld_acc ? ptr_inc(ld_slot) : ld_slot;
    head_d = drain ? ptr_inc(head_q) : head_q;
    count_d = count_q + CW'(alu_acc) + CW'(ld_acc) - CW'(drain);
  end

  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    // Walk oldest to youngest so the last match left standing is the youngest.
    for (int i = 0; i < DEPTH; i++) begin
      scan_sum = {1'b0, head_q} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(DEPTH)) scan_sum = scan_sum - (PW+1)'(DEPTH);
      scan_idx = scan_sum[PW-1:0];
      if (CW'(i) < count_q) begin
        if ((rr1_address != '0) && (mem_addr_q[scan_idx] == rr1_address)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data_q[scan_idx];
        end
        if ((rr2_address != '0) && (mem_addr_q[scan_idx] == rr2_address)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data_q[scan_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign rf_we         = drain;
  assign rf_wr_address = (count_q != '0) ? mem_addr_q[head_q] : '0;
  assign rf_wr_data    = (count_q != '0) ? mem_data_q[head_q] : '0;
  assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// tb_rf_writeback: randomized and directed bench with a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_rf_writeback;

  localparam int DW    = 8;
  localparam int RFW   = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [RFW-1:0] a;
    logic [DW-1:0]  d;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           alu_valid = 1'b0;
  logic [RFW-1:0] alu_addr = '0;
  logic [DW-1:0]  alu_data = '0;
  logic           alu_stall;
  logic           ld_valid = 1'b0;
  logic [RFW-1:0] ld_addr = '0;
  logic [DW-1:0]  ld_data = '0;
  logic           ld_ready;
  logic           rf_hold = 1'b0;
  logic           rf_we;
  logic [RFW-1:0] rf_wr_address;
  logic [DW-1:0]  rf_wr_data;
  logic [RFW-1:0] rr1_address = '0;
  logic [RFW-1:0] rr2_address = '0;
  logic           fwd1_hit, fwd2_hit;
  logic [DW-1:0]  fwd1_data, fwd2_data;
  logic [CW-1:0]  count;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];

  rf_writeback #(.DW(DW), .RFW(RFW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_wr_address(rf_wr_address), .rf_wr_data(rf_wr_data),
    .rr1_address(rr1_address), .rr2_address(rr2_address),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [RFW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [RFW-1:0] la, input logic [DW-1:0] ldd,
                       input logic hold, input logic [RFW-1:0] r1, input logic [RFW-1:0] r2);
    alu_valid = av;  alu_addr = aa; alu_data = ad;
    ld_valid  = lv;  ld_addr  = la; ld_data  = ldd;
    rf_hold   = hold; rr1_address = r1; rr2_address = r2;
  endtask

  task automatic idle(input logic hold, input logic [RFW-1:0] r1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, hold, r1, '0);
  endtask

  // One clock: compare every output against the model at the falling edge,
  // then advance the model across the rising edge.
  task automatic step();
    int   n, free, alu_acc, ld_acc;
    logic drain, alu_need, exp_stall, exp_ldr;
    logic h1, h2;
    logic [DW-1:0] d1, d2;
    ent_t head;
    @(negedge clk);
    n        = q.size();
    drain    = (n > 0) && !rf_hold;
    free     = DEPTH - n + (drain ? 1 : 0);
    alu_need = alu_valid && (alu_addr != 0);
    exp_stall = alu_need && (free == 0);
    alu_acc  = (alu_need && !exp_stall) ? 1 : 0;
    exp_ldr  = (ld_addr == 0) || ((free - alu_acc) >= 1);
    ld_acc   = (ld_valid && (ld_addr != 0) && exp_ldr) ? 1 : 0;
    head     = (n > 0) ? q[0] : '0;
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    for (int j = n - 1; j >= 0; j--) begin
      if (!h1 && rr1_address != 0 && q[j].a == rr1_address) begin h1 = 1'b1; d1 = q[j].d; end
      if (!h2 && rr2_address != 0 && q[j].a == rr2_address) begin h2 = 1'b1; d2 = q[j].d; end
    end
    check("count",     32'(count),         32'(n));
    check("rf_we",     32'(rf_we),         32'(drain));
    check("wr_addr",   32'(rf_wr_address), 32'(head.a));
    check("wr_data",   32'(rf_wr_data),    32'(head.d));
    check("alu_stall", 32'(alu_stall),     32'(exp_stall));
    check("ld_ready",  32'(ld_ready),      32'(exp_ldr));
    check("fwd1_hit",  32'(fwd1_hit),      32'(h1));
    check("fwd1_data", 32'(fwd1_data),     32'(d1));
    check("fwd2_hit",  32'(fwd2_hit),      32'(h2));
    check("fwd2_data", 32'(fwd2_data),     32'(d2));
    @(posedge clk);
    if (rst_n) begin
      if (drain) void'(q.pop_front());
      if (alu_acc != 0) q.push_back('{a: alu_addr, d: alu_data});
      if (ld_acc != 0)  q.push_back('{a: ld_addr,  d: ld_data});
    end else begin
      q.delete();
    end
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    q.delete();
  endtask

  initial begin
    idle(1'b0, '0);
    #2;
    check("reset_we",    32'(rf_we),         32'd0);
    check("reset_count", 32'(count),         32'd0);
    check("reset_addr",  32'(rf_wr_address), 32'd0);
    check("reset_data",  32'(rf_wr_data),    32'd0);
    check("reset_ldr",   32'(ld_ready),      32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single ALU write appears one cycle later.
    drive(1'b1, 2'd2, 8'h5A, 1'b0, '0, '0, 1'b0, 2'd2, '0);
    step();
    idle(1'b0, 2'd2);
    #1;
    check("t1_we",    32'(rf_we),         32'd1);
    check("t1_addr",  32'(rf_wr_address), 32'd2);
    check("t1_data",  32'(rf_wr_data),    32'h5A);
    check("t1_count", 32'(count),         32'd1);
    check("t1_fwd",   32'(fwd1_data),     32'h5A);
    step();
    check("t1_we_off", 32'(rf_we), 32'd0);
    check("t1_cnt0",   32'(count), 32'd0);

    // Zero-register request is swallowed.
    drive(1'b1, 2'd0, 8'h77, 1'b0, '0, '0, 1'b0, 2'd0, 2'd0);
    #1;
    check("t2_stall", 32'(alu_stall), 32'd0);
    step();
    idle(1'b0, '0);
    #1;
    check("t2_count", 32'(count), 32'd0);
    check("t2_we",    32'(rf_we), 32'd0);
    step();

    // Concurrent ALU and load: ALU first.
    drive(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0, 2'd1, 2'd3);
    #1;
    check("t3_ldr", 32'(ld_ready), 32'd1);
    step();
    idle(1'b0, '0);
    #1;
    check("t3_count", 32'(count),         32'd2);
    check("t3_a1",    32'(rf_wr_address), 32'd1);
    check("t3_d1",    32'(rf_wr_data),    32'h11);
    step();
    check("t3_a2",    32'(rf_wr_address), 32'd3);
    check("t3_d2",    32'(rf_wr_data),    32'h33);
    step();

    // Hold, fill, back-pressure, release with same-cycle free slot.
    drive(1'b1, 2'd1, 8'hA0, 1'b0, '0, '0, 1'b1, 2'd1, '0);
    step();
    drive(1'b1, 2'd1, 8'hA1, 1'b0, '0, '0, 1'b1, 2'd1, '0);
    step();
    idle(1'b1, 2'd1);
    #1;
    check("t4_count", 32'(count),     32'd2);
    check("t4_hit",   32'(fwd1_hit),  32'd1);
    check("t4_fwd",   32'(fwd1_data), 32'hA1);
    drive(1'b1, 2'd1, 8'hB0, 1'b1, 2'd2, 8'h44, 1'b1, 2'd1, '0);
    #1;
    check("t4_stall", 32'(alu_stall), 32'd1);
    check("t4_ldr",   32'(ld_ready),  32'd0);
    step();
    drive(1'b1, 2'd1, 8'hB0, 1'b0, '0, '0, 1'b0, 2'd1, '0);
    #1;
    check("t4_rel_stall", 32'(alu_stall),  32'd0);
    check("t4_rel_data",  32'(rf_wr_data), 32'hA0);
    step();
    idle(1'b0, 2'd1);
    #1;
    check("t4_d2",  32'(rf_wr_data), 32'hA1);
    check("t4_fwd2", 32'(fwd1_data), 32'hB0);
    step();
    check("t4_d3",  32'(rf_wr_data), 32'hB0);
    step();

    // Ten back-to-back accepts wrap the pointers repeatedly.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, RFW'(1 + (i % 3)), DW'(8'hC0 + i), 1'b0, '0, '0, 1'b0, RFW'(1 + (i % 3)), 2'd2);
      step();
    end
    idle(1'b0, '0);
    step(); step();

    // Reset with two entries pending.
    drive(1'b1, 2'd3, 8'hD0, 1'b1, 2'd2, 8'hD1, 1'b1, 2'd3, 2'd2);
    step();
    idle(1'b1, 2'd3);
    #1;
    check("t6_pre_count", 32'(count), 32'd2);
    rf_hold = 1'b0;
    async_reset();
    #1;
    check("t6_we",    32'(rf_we), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_hit",   32'(fwd1_hit), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();

    // Randomized traffic with occasional holds and resets.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 6), RFW'($urandom), DW'($urandom),
            ($urandom_range(0, 9) < 5), RFW'($urandom), DW'($urandom),
            ($urandom_range(0, 9) < 3), RFW'($urandom), RFW'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset();
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    idle(1'b0, '0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
